// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp
//  Description : Data-memory responder for the load/store unit's memory port.
//                Accepts a chip-enable/write-enable/byte-select request,
//                holds the pipeline for a programmable number of wait states
//                and then commits a byte-masked word store or a full-word
//                load against an internal synchronous RAM.
//
//  Ports
//    clk_i         in   1   core clock, rising edge
//    n_rst_i       in   1   asynchronous active-low reset
//    mem_ce_i      in   1   request valid
//    mem_we_i      in   1   1 = store, 0 = load
//    mem_addr_i    in  32   byte address (bits [1:0] ignored)
//    mem_sel_i     in   4   byte-lane enables for stores
//    mem_data_i    in  32   store data, lane-replicated
//    mem_data_o    out 32   load data, valid in the response cycle
//    stall_req_o   out  1   access outstanding, hold the pipeline
//    access_err_o  out  1   one-cycle pulse: address outside the RAM window
//
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_resp #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    output logic        access_err_o
);

    localparam int unsigned c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]  c_WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic        c_NO_WAIT   = (WAIT_STATES == 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // ------------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    // RAM contents are deliberately not reset.
    logic [31:0] r_mem [c_DEPTH];

    // ------------------------------------------------------------------------
    // Commit decode
    // ------------------------------------------------------------------------
    logic        w_idle;
    logic        w_commit;
    logic        w_c_we;
    logic [31:0] w_c_addr;
    logic [3:0]  w_c_sel;
    logic [31:0] w_c_wdata;
    logic [31:0] w_off;
    logic        w_in_range;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_idle = (r_state == c_ST_IDLE);

    // With zero wait states the commit happens on the accept edge, before the
    // request registers hold anything, so the live inputs are used instead.
    // Gating with n_rst_i keeps the RAM untouched while reset is held.
    assign w_commit = n_rst_i & mem_ce_i &
                      ((w_idle & c_NO_WAIT) |
                       ((r_state == c_ST_WAIT) & (r_wait_cnt == 4'd1)));

    assign w_c_we    = w_idle ? mem_we_i   : r_we;
    assign w_c_addr  = w_idle ? mem_addr_i : r_addr;
    assign w_c_sel   = w_idle ? mem_sel_i  : r_sel;
    assign w_c_wdata = w_idle ? mem_data_i : r_wdata;

    // Offset into the window; anything at or above 4*DEPTH bytes (including a
    // wrapped negative offset) falls outside the RAM.
    assign w_off      = w_c_addr - BASE_ADDR;
    assign w_in_range = ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);
    assign w_idx      = w_off[ADDR_WIDTH+1:2];

    // ------------------------------------------------------------------------
    // Control FSM, request capture and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state    <= c_ST_IDLE;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_sel      <= 4'd0;
            r_wdata    <= 32'd0;
            r_wait_cnt <= 4'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (mem_ce_i) begin
                        r_we       <= mem_we_i;
                        r_addr     <= mem_addr_i;
                        r_sel      <= mem_sel_i;
                        r_wdata    <= mem_data_i;
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_state    <= c_NO_WAIT ? c_ST_RESP : c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (!mem_ce_i) begin
                        // Flush: abandon the access without committing.
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                        if (r_wait_cnt == 4'd1) begin
                            r_state <= c_ST_RESP;
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            if (w_commit) begin
                if (!w_in_range) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end else if (!w_c_we) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // RAM write port: byte-lane masked, in-range stores only
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_commit && w_c_we && w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (w_c_sel[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_c_wdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall_req_o  = mem_ce_i & (r_state != c_ST_RESP) & n_rst_i;
    assign mem_data_o   = r_rdata;
    assign access_err_o = r_err & (r_state == c_ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_resp
//  Description : Directed self-checking bench for dmem_resp. Three instances
//                cover WAIT_STATES = 1, 3 and 0.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        rst_n;

    // index 0: WAIT_STATES=1, index 1: WAIT_STATES=3, index 2: WAIT_STATES=0
    logic        ce    [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [3:0]  sel   [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        err   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut_w1 (
        .clk_i(clk), .n_rst_i(rst_n), .mem_ce_i(ce[0]), .mem_we_i(we[0]),
        .mem_addr_i(addr[0]), .mem_sel_i(sel[0]), .mem_data_i(wdata[0]),
        .mem_data_o(rdata[0]), .stall_req_o(stall[0]), .access_err_o(err[0]));

    dmem_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut_w3 (
        .clk_i(clk), .n_rst_i(rst_n), .mem_ce_i(ce[1]), .mem_we_i(we[1]),
        .mem_addr_i(addr[1]), .mem_sel_i(sel[1]), .mem_data_i(wdata[1]),
        .mem_data_o(rdata[1]), .stall_req_o(stall[1]), .access_err_o(err[1]));

    dmem_resp #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_w0 (
        .clk_i(clk), .n_rst_i(rst_n), .mem_ce_i(ce[2]), .mem_we_i(we[2]),
        .mem_addr_i(addr[2]), .mem_sel_i(sel[2]), .mem_data_i(wdata[2]),
        .mem_data_o(rdata[2]), .stall_req_o(stall[2]), .access_err_o(err[2]));

    // Drives one access on instance d starting at posedge+1 and records what
    // was observed; returns at posedge+1 of the cycle after the response.
    task automatic do_access(input int d, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] wd,
                             output int n_stall, output int n_err,
                             output int n_cyc, output logic [31:0] resp);
        bit done;
        done    = 1'b0;
        n_stall = 0;
        n_err   = 0;
        n_cyc   = 0;
        resp    = 32'hxxxx_xxxx;
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd;
        while (!done && n_cyc < 40) begin
            #1;
            if (stall[d]) n_stall++;
            else begin
                resp = rdata[d];
                done = 1'b1;
            end
            if (err[d]) n_err++;
            n_cyc++;
            @(posedge clk); #1;
        end
        ce[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce[0] = 1'b1;
        #12;
        total++; if (stall[0] !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall[0]); end
        total++; if (rdata[0] !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 00000000", rdata[0]); end
        total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++; if (stall[0] !== 1'b1) begin bad++; $display("FAIL release_stall: got %b want 1", stall[0]); end
        ce[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        int ns, ne, nc;
        logic [31:0] rv;
        do_access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, ns, ne, nc, rv);
        total++; if (ns !== 2) begin bad++; $display("FAIL sw_stall_cycles: got %0d want 2", ns); end
        total++; if (nc !== 3) begin bad++; $display("FAIL sw_cycles: got %0d want 3", nc); end
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL sw_data_hold: got %h want 00000000", rv); end
        do_access(0, 1'b0, 32'h10, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (ns !== 2) begin bad++; $display("FAIL lw_stall_cycles: got %0d want 2", ns); end
        total++; if (rv !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", rv); end
        total++; if (ne !== 0) begin bad++; $display("FAIL lw_err: got %0d want 0", ne); end
    endtask

    task automatic test_byte_lanes();
        int ns, ne, nc;
        logic [31:0] rv;
        do_access(0, 1'b1, 32'h11, 4'b0010, 32'h5A5A5A5A, ns, ne, nc, rv);
        total++; if (rv !== 32'hDEADBEEF) begin bad++; $display("FAIL sb_data_hold: got %h want deadbeef", rv); end
        do_access(0, 1'b0, 32'h10, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (rv !== 32'hDEAD5AEF) begin bad++; $display("FAIL sb_readback: got %h want dead5aef", rv); end
        do_access(0, 1'b1, 32'h12, 4'b1100, 32'h12341234, ns, ne, nc, rv);
        do_access(0, 1'b0, 32'h10, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (rv !== 32'h12345AEF) begin bad++; $display("FAIL sh_readback: got %h want 12345aef", rv); end
        do_access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, ns, ne, nc, rv);
        do_access(0, 1'b0, 32'h10, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (rv !== 32'h12345AEF) begin bad++; $display("FAIL sel0_noop: got %h want 12345aef", rv); end
    endtask

    task automatic test_out_of_range();
        int ns, ne, nc;
        logic [31:0] rv;
        do_access(0, 1'b0, 32'h4000, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (ne !== 1) begin bad++; $display("FAIL oor_err_cycles: got %0d want 1", ne); end
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL oor_data: got %h want 00000000", rv); end
        #1;
        total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL oor_err_after: got %b want 0", err[0]); end
        @(posedge clk); #1;
        do_access(0, 1'b0, 32'h10, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (ne !== 0) begin bad++; $display("FAIL inrange_err: got %0d want 0", ne); end
        total++; if (rv !== 32'h12345AEF) begin bad++; $display("FAIL inrange_data: got %h want 12345aef", rv); end
    endtask

    task automatic test_flush();
        int ns, ne, nc;
        logic [31:0] rv;
        do_access(1, 1'b1, 32'h20, 4'hF, 32'h11111111, ns, ne, nc, rv);
        total++; if (ns !== 4) begin bad++; $display("FAIL w3_sw_stall_cycles: got %0d want 4", ns); end
        total++; if (nc !== 5) begin bad++; $display("FAIL w3_sw_cycles: got %0d want 5", nc); end
        // cycle 0: store request appears
        ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; sel[1] = 4'hF; wdata[1] = 32'h22222222;
        #1;
        total++; if (stall[1] !== 1'b1) begin bad++; $display("FAIL flush_stall_c0: got %b want 1", stall[1]); end
        @(posedge clk); #1;   // cycle 1
        @(posedge clk); #1;   // cycle 2: drop ce
        ce[1] = 1'b0;
        #1;
        total++; if (stall[1] !== 1'b0) begin bad++; $display("FAIL flush_stall_c2: got %b want 0", stall[1]); end
        total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", err[1]); end
        @(posedge clk); #1;   // cycle 3: must be IDLE, a new load is accepted
        do_access(1, 1'b0, 32'h20, 4'h0, 32'h0, ns, ne, nc, rv);
        total++; if (nc !== 5) begin bad++; $display("FAIL flush_next_cycles: got %0d want 5", nc); end
        total++; if (rv !== 32'h11111111) begin bad++; $display("FAIL flush_no_write: got %h want 11111111", rv); end
    endtask

    task automatic test_back_to_back();
        int ns, ne, nc, sum_cyc;
        logic [31:0] rv;
        for (int i = 0; i < 5; i++) begin
            do_access(2, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), ns, ne, nc, rv);
        end
        sum_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            do_access(2, 1'b0, 32'h100 + 32'(4*i), 4'h0, 32'h0, ns, ne, nc, rv);
            sum_cyc += nc;
            total++; if (ns !== 1) begin bad++; $display("FAIL b2b_stall[%0d]: got %0d want 1", i, ns); end
            total++; if (rv !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rv, 32'hA000_0000 + 32'(i)); end
        end
        total++; if (sum_cyc !== 10) begin bad++; $display("FAIL b2b_total_cycles: got %0d want 10", sum_cyc); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ce[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; sel[i] = 4'd0; wdata[i] = 32'd0;
        end
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_out_of_range();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
